// File: rtl/sp_ram_ctrl.sv
// Single-port synchronous RAM with req/ready handshake, registered read data and a
// post-reset clear sweep. Define MEM_PARITY_EN to store and check an even-parity bit per word.
module sp_ram_ctrl #(
  parameter int unsigned        DATA_W         = 8,
  parameter int unsigned        ADDR_W         = 10,
  parameter int unsigned        DEPTH          = 512,
  parameter bit                 CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0]  CLEAR_VAL      = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              inj_par_err,
  output logic              ready,
  output logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              rvalid,
  output logic              addr_err,
  output logic              parity_err
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef MEM_PARITY_EN
  localparam int unsigned MemW = DATA_W + 1;
`else
  localparam int unsigned MemW = DATA_W;
`endif

  typedef enum logic [0:0] {StClear, StIdle} state_e;
  localparam state_e StReset = CLEAR_ON_RESET ? StClear : StIdle;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   clr_cnt_q, clr_cnt_d;
  logic [MemW-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0] data_out_q;
  logic              rvalid_q, addr_err_q, parity_err_q;

  logic              accept, in_range, mem_we, rd_par_err;
  logic [IdxW-1:0]   addr_idx, mem_idx;
  logic [MemW-1:0]   wr_word, clr_word, rd_word, mem_wdata;

  assign ready    = (state_q == StIdle) && !rst;
  assign busy     = (state_q == StClear);
  assign accept   = req && ready;
  // Full-width compare so out-of-range addresses never alias onto low words.
  assign in_range = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));
  assign addr_idx = addr[IdxW-1:0];
  assign rd_word  = mem_q[addr_idx];

`ifdef MEM_PARITY_EN
  assign wr_word    = {(^data_in) ^ inj_par_err, data_in};
  assign clr_word   = {^CLEAR_VAL, CLEAR_VAL};
  assign rd_par_err = (^rd_word[DATA_W-1:0]) != rd_word[DATA_W];
`else
  logic unused_inj_par_err;
  assign unused_inj_par_err = inj_par_err;
  assign wr_word    = data_in;
  assign clr_word   = CLEAR_VAL;
  assign rd_par_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    mem_we    = 1'b0;
    mem_idx   = addr_idx;
    mem_wdata = wr_word;
    case (state_q)
      StClear: begin
        mem_we    = !rst;
        mem_idx   = clr_cnt_q;
        mem_wdata = clr_word;
        if (clr_cnt_q == IdxW'(DEPTH - 1)) begin
          state_d = StIdle;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      StIdle: begin
        mem_we = accept && we && in_range;
      end
      default: state_d = StReset;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StReset;
      clr_cnt_q    <= '0;
      data_out_q   <= '0;
      rvalid_q     <= 1'b0;
      addr_err_q   <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      rvalid_q     <= accept && !we;
      addr_err_q   <= accept && !in_range;
      parity_err_q <= accept && !we && in_range && rd_par_err;
      if (accept && !we) begin
        data_out_q <= in_range ? rd_word[DATA_W-1:0] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_idx] <= mem_wdata;
    end
  end

  assign data_out   = data_out_q;
  assign rvalid     = rvalid_q;
  assign addr_err   = addr_err_q;
  assign parity_err = parity_err_q;

endmodule

// File: tb/tb_sp_ram_ctrl.sv
// Directed bench for sp_ram_ctrl (DEPTH=300, non-power-of-two) with a cycle model
// and a read-result scoreboard queue.
module tb_sp_ram_ctrl;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 300;
`ifdef MEM_PARITY_EN
  localparam bit ParEn = 1'b1;
`else
  localparam bit ParEn = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst, req, we, inj_par_err;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic              ready, busy, rvalid, addr_err, parity_err;
  logic [DATA_W-1:0] data_out;

  always #5 clk = ~clk;

  sp_ram_ctrl #(
    .DATA_W        (DATA_W),
    .ADDR_W        (ADDR_W),
    .DEPTH         (DEPTH),
    .CLEAR_ON_RESET(1'b1),
    .CLEAR_VAL     (8'h00)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .data_in    (data_in),
    .inj_par_err(inj_par_err),
    .ready      (ready),
    .busy       (busy),
    .data_out   (data_out),
    .rvalid     (rvalid),
    .addr_err   (addr_err),
    .parity_err (parity_err)
  );

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic              p;
  } exp_t;

  exp_t              sb_q[$];
  logic [DATA_W-1:0] mem_m [DEPTH];
  logic              par_m [DEPTH];
  int                clr_left = DEPTH;
  logic              exp_rv   = 1'b0;
  logic              exp_ae   = 1'b0;
  logic [DATA_W-1:0] exp_dout = '0;
  int                total    = 0;
  int                bad      = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // One clock: predict acceptance, advance the model, then check every output.
  task automatic cyc();
    logic rst_s, acc, inr;
    exp_t e;
    rst_s = rst;
    inr   = (addr < DEPTH);
    acc   = req && !rst_s && (clr_left == 0);
    if (acc && !we) begin
      e.d = inr ? mem_m[addr] : '0;
      e.p = inr && ParEn && par_m[addr];
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (rst_s) begin
      clr_left = DEPTH;
      sb_q.delete();
      exp_dout = '0;
      exp_rv   = 1'b0;
      exp_ae   = 1'b0;
    end else if (clr_left > 0) begin
      mem_m[DEPTH - clr_left] = '0;
      par_m[DEPTH - clr_left] = 1'b0;
      clr_left--;
      exp_rv = 1'b0;
      exp_ae = 1'b0;
    end else begin
      exp_rv = acc && !we;
      exp_ae = acc && !inr;
      if (acc && we && inr) begin
        mem_m[addr] = data_in;
        par_m[addr] = inj_par_err;
      end
    end
    chk("ready", ready, (clr_left == 0) && !rst);
    chk("busy", busy, clr_left > 0);
    chk("rvalid", rvalid, exp_rv);
    chk("addr_err", addr_err, exp_ae);
    if (rvalid === 1'b1) begin
      chk("sb_nonempty", sb_q.size() > 0, 1'b1);
      if (sb_q.size() > 0) begin
        e        = sb_q.pop_front();
        exp_dout = e.d;
        chk("parity_err", parity_err, e.p);
      end
    end else begin
      chk("parity_err_idle", parity_err, 1'b0);
    end
    chk("data_out", data_out, exp_dout);
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wr(input int a, input int d, input logic inj);
    req = 1'b1; we = 1'b1; addr = ADDR_W'(a); data_in = DATA_W'(d); inj_par_err = inj;
    cyc();
    req = 1'b0; we = 1'b0; inj_par_err = 1'b0;
  endtask

  task automatic rd(input int a);
    req = 1'b1; we = 1'b0; addr = ADDR_W'(a);
    cyc();
    req = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (ready !== 1'b1 && n < int'(DEPTH) + 10) begin
      cyc();
      n++;
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; data_in = '0; inj_par_err = 1'b0;
    cyc();
    rst = 1'b0;

    // Sweep, with a write attempted while not ready that must be dropped.
    idle(3);
    wr(2, 8'hFF, 1'b0);
    wait_ready(n);
    chk("sweep_len", n + 4, DEPTH);
    rd(0);
    rd(DEPTH - 1);
    rd(2);

    // Write then read, then back-to-back reads.
    wr(5, 8'h3C, 1'b0);
    rd(5);
    idle(1);
    rd(5); rd(6); rd(5); rd(6);
    idle(1);

    // Out-of-range accesses at the DEPTH boundary and above; no aliasing to word 44.
    wr(300, 8'hAA, 1'b0);
    rd(300);
    rd(44);
    wr(1023, 8'h55, 1'b0);
    rd(1023);
    rd(299);
    idle(1);

    // Parity injection (parity_err expected only when the macro is defined).
    wr(9, 8'h07, 1'b1);
    wr(10, 8'h07, 1'b0);
    rd(9);
    rd(10);
    idle(1);

    // Reset on the 100th cycle of a sweep restarts it; a pending read is cancelled.
    wr(0, 8'h11, 1'b0);
    rd(0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    idle(99);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    wait_ready(n);
    chk("resweep_len", n, DEPTH);
    rd(0);
    rd(5);
    idle(2);

    chk("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
